// File: rtl/iq_pkg.sv
// Shared types and constants for the instruction queue.
//   INST_W / PC_W : instruction and PC widths
//   iq_entry_t    : one queue entry, {pc, inst}
//   ptr_w()       : pointer width for a given queue depth
package iq_pkg;

    localparam int unsigned INST_W  = 32;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned ENTRY_W = INST_W + PC_W;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } iq_entry_t;

    // Pointer width for a power-of-two depth; never narrower than one bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/iq_storage.sv
// Entry storage for the instruction queue: DEPTH x iq_entry_t register array.
// Ports:
//   clk            : rising-edge clock
//   we0/wa0/wd0    : write port 0 (oldest slot of a fetch bundle)
//   we1/wa1/wd1    : write port 1 (second slot of a fetch bundle)
//   ra0/rd0        : combinational read port 0 (head)
//   ra1/rd1        : combinational read port 1 (head + 1)
// Contents are not reset; the controller masks any slot that holds no entry.
module iq_storage
    import iq_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PW    = ptr_w(DEPTH)
)
(
    input  logic            clk,
    input  logic            we0,
    input  logic [PW-1:0]   wa0,
    input  iq_entry_t       wd0,
    input  logic            we1,
    input  logic [PW-1:0]   wa1,
    input  iq_entry_t       wd1,
    input  logic [PW-1:0]   ra0,
    output iq_entry_t       rd0,
    input  logic [PW-1:0]   ra1,
    output iq_entry_t       rd1
);

    iq_entry_t mem [DEPTH];

    // The controller never drives both ports to the same address.
    always_ff @(posedge clk) begin
        if (we0) begin
            mem[wa0] <= wd0;
        end
        if (we1) begin
            mem[wa1] <= wd1;
        end
    end

    assign rd0 = mem[ra0];
    assign rd1 = mem[ra1];

endmodule

// File: rtl/inst_queue_ctrl.sv
// Instruction queue between fetch and decode: up to two instructions in and
// up to two out per cycle, circular buffer of DEPTH {pc, inst} entries.
// Ports:
//   clk, rstn                 : clock, asynchronous active-low reset
//   flush                     : drop all queued entries at the next edge
//   fetch_valid/fetch_ready   : fetch handshake (ready is combinational)
//   fetch_cnt                 : bundle size 0..2 (3 is treated as 2)
//   fetch_inst0/1, fetch_pc0/1: bundle payload, slot 0 oldest
//   id_valid/id_ready         : decode handshake
//   id_cnt                    : entries presented, min(count, 2)
//   id_inst0/1, id_pc0/1      : presented payload, unused slots read 0
//   empty, count              : occupancy status
// Optional build macro IQ_PERF_CNT_EN adds saturating counters
//   perf_empty_cyc (cycles empty) and perf_full_cyc (fetch offered but refused).
module inst_queue_ctrl
    import iq_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PW    = ptr_w(DEPTH),
    localparam int unsigned CW    = PW + 1
)
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              fetch_valid,
    output logic              fetch_ready,
    input  logic [1:0]        fetch_cnt,
    input  logic [INST_W-1:0] fetch_inst0,
    input  logic [INST_W-1:0] fetch_inst1,
    input  logic [PC_W-1:0]   fetch_pc0,
    input  logic [PC_W-1:0]   fetch_pc1,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [1:0]        id_cnt,
    output logic [INST_W-1:0] id_inst0,
    output logic [INST_W-1:0] id_inst1,
    output logic [PC_W-1:0]   id_pc0,
    output logic [PC_W-1:0]   id_pc1,
    output logic              empty,
    output logic [CW-1:0]     count
`ifdef IQ_PERF_CNT_EN
    ,
    output logic [31:0]       perf_empty_cyc,
    output logic [31:0]       perf_full_cyc
`endif
);

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] head_nxt;
    logic [PW-1:0] tail_nxt;
    logic [CW-1:0] count_nxt;
    logic [1:0]    fetch_n;
    logic [1:0]    push_n;
    logic [1:0]    pop_n;
    iq_entry_t     wd0;
    iq_entry_t     wd1;
    iq_entry_t     rd0;
    iq_entry_t     rd1;
    logic          we0;
    logic          we1;

    // Handshake and occupancy decode, all from registered state.
    assign fetch_n     = (fetch_cnt == 2'd3) ? 2'd2 : fetch_cnt;
    assign fetch_ready = (CW'(DEPTH) - count) >= CW'(2);
    assign push_n      = (fetch_valid && fetch_ready) ? fetch_n : 2'd0;
    assign id_valid    = (count != '0);
    assign id_cnt      = (count >= CW'(2)) ? 2'd2 : count[1:0];
    assign pop_n       = (id_valid && id_ready) ? id_cnt : 2'd0;
    assign empty       = (count == '0);

    // Pointer/count next state; flush wins over any push or pop.
    always_comb begin
        head_nxt  = head;
        tail_nxt  = tail;
        count_nxt = count;
        if (flush) begin
            head_nxt  = '0;
            tail_nxt  = '0;
            count_nxt = '0;
        end else begin
            head_nxt  = head + PW'(pop_n);
            tail_nxt  = tail + PW'(push_n);
            count_nxt = count + CW'(push_n) - CW'(pop_n);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head_nxt;
            tail  <= tail_nxt;
            count <= count_nxt;
        end
    end

    // Writes are suppressed under flush so dropped bundles never land.
    assign we0 = !flush && (push_n != 2'd0);
    assign we1 = !flush && (push_n == 2'd2);
    assign wd0 = '{pc: fetch_pc0, inst: fetch_inst0};
    assign wd1 = '{pc: fetch_pc1, inst: fetch_inst1};

    iq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk (clk),
        .we0 (we0),
        .wa0 (tail),
        .wd0 (wd0),
        .we1 (we1),
        .wa1 (tail + PW'(1)),
        .wd1 (wd1),
        .ra0 (head),
        .rd0 (rd0),
        .ra1 (head + PW'(1)),
        .rd1 (rd1)
    );

    // Slots beyond id_cnt read zero so stale storage never leaks out.
    assign id_inst0 = id_valid         ? rd0.inst : '0;
    assign id_pc0   = id_valid         ? rd0.pc   : '0;
    assign id_inst1 = (id_cnt == 2'd2) ? rd1.inst : '0;
    assign id_pc1   = (id_cnt == 2'd2) ? rd1.pc   : '0;

`ifdef IQ_PERF_CNT_EN
    // Saturating event counters; only reset clears them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_empty_cyc <= '0;
            perf_full_cyc  <= '0;
        end else begin
            if (empty && (perf_empty_cyc != '1)) begin
                perf_empty_cyc <= perf_empty_cyc + 32'd1;
            end
            if (fetch_valid && !fetch_ready && (perf_full_cyc != '1)) begin
                perf_full_cyc <= perf_full_cyc + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_queue_ctrl.sv
// Directed bench for inst_queue_ctrl (DEPTH = 8). Perf counter checks are
// compiled in only when IQ_PERF_CNT_EN is defined.
module tb_inst_queue_ctrl;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [1:0]  fetch_cnt;
    logic [31:0] fetch_inst0, fetch_inst1, fetch_pc0, fetch_pc1;
    logic        id_valid;
    logic        id_ready;
    logic [1:0]  id_cnt;
    logic [31:0] id_inst0, id_inst1, id_pc0, id_pc1;
    logic        empty;
    logic [3:0]  count;
`ifdef IQ_PERF_CNT_EN
    logic [31:0] perf_empty_cyc, perf_full_cyc;
    logic [31:0] p0;
`endif

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    int seq;
    logic [1:0] n;

    inst_queue_ctrl #(.DEPTH(8)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush       (flush),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_cnt   (fetch_cnt),
        .fetch_inst0 (fetch_inst0),
        .fetch_inst1 (fetch_inst1),
        .fetch_pc0   (fetch_pc0),
        .fetch_pc1   (fetch_pc1),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_cnt      (id_cnt),
        .id_inst0    (id_inst0),
        .id_inst1    (id_inst1),
        .id_pc0      (id_pc0),
        .id_pc1      (id_pc1),
        .empty       (empty),
        .count       (count)
`ifdef IQ_PERF_CNT_EN
        ,
        .perf_empty_cyc (perf_empty_cyc),
        .perf_full_cyc  (perf_full_cyc)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] cnt, input logic [31:0] i0, input logic [31:0] i1);
        fetch_valid = 1'b1;
        fetch_cnt   = cnt;
        fetch_inst0 = i0;
        fetch_inst1 = i1;
        fetch_pc0   = 32'h1000_0000 | i0;
        fetch_pc1   = 32'h1000_0000 | i1;
    endtask

    task automatic idle_fetch();
        fetch_valid = 1'b0;
        fetch_cnt   = 2'd0;
    endtask

    task automatic sample_out();
        if (id_valid) begin
            got_q.push_back({id_pc0, id_inst0});
            if (id_cnt == 2'd2) got_q.push_back({id_pc1, id_inst1});
        end
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; id_ready = 1'b0;
        fetch_inst0 = '0; fetch_inst1 = '0; fetch_pc0 = '0; fetch_pc1 = '0;
        idle_fetch();
        #3;
        check("rst_empty",    64'(empty),       64'd1);
        check("rst_ready",    64'(fetch_ready), 64'd1);
        check("rst_id_valid", 64'(id_valid),    64'd0);
        check("rst_id_cnt",   64'(id_cnt),      64'd0);
        check("rst_count",    64'(count),       64'd0);
        check("rst_id_inst0", 64'(id_inst0),    64'd0);
        #9 rstn = 1'b1;
        cycle();

        // Basic push of two, visible one cycle later.
        offer(2'd2, 32'h11, 32'h22);
        cycle();
        idle_fetch();
        check("b_id_valid", 64'(id_valid), 64'd1);
        check("b_id_cnt",   64'(id_cnt),   64'd2);
        check("b_inst0",    64'(id_inst0), 64'h11);
        check("b_inst1",    64'(id_inst1), 64'h22);
        check("b_pc0",      64'(id_pc0),   64'h1000_0011);
        check("b_pc1",      64'(id_pc1),   64'h1000_0022);
        check("b_count",    64'(count),    64'd2);
        id_ready = 1'b1;
        cycle();
        id_ready = 1'b0;
        check("b_drain_empty", 64'(empty), 64'd1);

        // Fill to full with two per cycle, no pops.
        for (int j = 0; j < 4; j++) begin
            offer(2'd2, 32'hA0 + 32'(2*j), 32'hA1 + 32'(2*j));
            cycle();
            check($sformatf("fill_count%0d", j), 64'(count), 64'(2*(j+1)));
            check($sformatf("fill_ready%0d", j), 64'(fetch_ready), (j < 3) ? 64'd1 : 64'd0);
        end
`ifdef IQ_PERF_CNT_EN
        p0 = perf_full_cyc;
`endif
        for (int j = 0; j < 3; j++) cycle();
        check("full_hold_count", 64'(count),    64'd8);
        check("full_hold_inst0", 64'(id_inst0), 64'hA0);
        check("full_hold_inst1", 64'(id_inst1), 64'hA1);
`ifdef IQ_PERF_CNT_EN
        check("perf_full_inc", 64'(perf_full_cyc), 64'(p0 + 32'd3));
`endif
        idle_fetch();
        id_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check($sformatf("drain_inst0_%0d", j), 64'(id_inst0), 64'hA0 + 64'(2*j));
            cycle();
        end
        id_ready = 1'b0;
        check("drain_count", 64'(count), 64'd0);

        // fetch_cnt 3 acts as 2, fetch_cnt 0 is a no-op.
        offer(2'd3, 32'h31, 32'h32);
        cycle();
        check("cnt3_count", 64'(count),    64'd2);
        check("cnt3_inst1", 64'(id_inst1), 64'h32);
        offer(2'd0, 32'h3E, 32'h3F);
        cycle();
        idle_fetch();
        check("cnt0_count", 64'(count), 64'd2);
        id_ready = 1'b1;
        cycle();
        id_ready = 1'b0;

        // Simultaneous pop of one and push of two.
        offer(2'd1, 32'h41, 32'h0);
        cycle();
        offer(2'd2, 32'h42, 32'h43);
        id_ready = 1'b1;
        check("sim_id_cnt", 64'(id_cnt),   64'd1);
        check("sim_inst0",  64'(id_inst0), 64'h41);
        check("sim_inst1",  64'(id_inst1), 64'h0);
        cycle();
        idle_fetch();
        id_ready = 1'b0;
        check("sim_count", 64'(count),    64'd2);
        check("sim_next0", 64'(id_inst0), 64'h42);
        check("sim_next1", 64'(id_inst1), 64'h43);
        id_ready = 1'b1;
        cycle();
        id_ready = 1'b0;

        // 20 alternating bundles of 1 and 2 with decode always ready; wraps.
        exp_q.delete();
        got_q.delete();
        seq = 0;
        id_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            n = (k % 2 == 0) ? 2'd1 : 2'd2;
            offer(n, 32'h500 + 32'(seq), 32'h500 + 32'(seq + 1));
            exp_q.push_back({32'h1000_0500 + 32'(seq), 32'h500 + 32'(seq)});
            if (n == 2'd2)
                exp_q.push_back({32'h1000_0500 + 32'(seq + 1), 32'h500 + 32'(seq + 1)});
            seq += int'(n);
            sample_out();
            cycle();
        end
        idle_fetch();
        for (int k = 0; k < 8; k++) begin
            sample_out();
            cycle();
        end
        id_ready = 1'b0;
        check("wrap_len", 64'(got_q.size()), 64'd30);
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("wrap_e%0d", i), (i < got_q.size()) ? got_q[i] : 64'hDEAD, exp_q[i]);
        check("wrap_empty", 64'(empty), 64'd1);

        // Flush with a concurrent push and pop at count 5.
        offer(2'd2, 32'h51, 32'h52); cycle();
        offer(2'd2, 32'h53, 32'h54); cycle();
        offer(2'd1, 32'h55, 32'h0);  cycle();
        check("fl_count5", 64'(count), 64'd5);
        offer(2'd2, 32'h5E, 32'h5F);
        flush = 1'b1;
        id_ready = 1'b1;
        cycle();
        flush = 1'b0;
        id_ready = 1'b0;
        idle_fetch();
        check("fl_count",    64'(count),    64'd0);
        check("fl_empty",    64'(empty),    64'd1);
        check("fl_id_valid", 64'(id_valid), 64'd0);
        offer(2'd1, 32'h61, 32'h0);
        cycle();
        idle_fetch();
        check("fl_after_count", 64'(count),    64'd1);
        check("fl_after_inst0", 64'(id_inst0), 64'h61);
        id_ready = 1'b1;
        cycle();
        id_ready = 1'b0;

        // Asynchronous reset mid-stream at count 3.
        offer(2'd2, 32'h71, 32'h72); cycle();
        offer(2'd1, 32'h73, 32'h0);  cycle();
        idle_fetch();
        check("ar_count3", 64'(count), 64'd3);
        #2 rstn = 1'b0;
        #1;
        check("ar_count",    64'(count),       64'd0);
        check("ar_empty",    64'(empty),       64'd1);
        check("ar_id_valid", 64'(id_valid),    64'd0);
        check("ar_id_cnt",   64'(id_cnt),      64'd0);
        check("ar_inst0",    64'(id_inst0),    64'd0);
        check("ar_ready",    64'(fetch_ready), 64'd1);
`ifdef IQ_PERF_CNT_EN
        check("ar_perf_full", 64'(perf_full_cyc), 64'd0);
`endif
        #3 rstn = 1'b1;
        cycle();
        check("ar_post_empty", 64'(empty), 64'd1);
        offer(2'd1, 32'h81, 32'h0);
        cycle();
        idle_fetch();
        check("ar_post_inst0", 64'(id_inst0), 64'h81);
        check("ar_post_count", 64'(count),    64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
